turn_sched_m: RTL and testbench

//  Game sequencer between the two movers (player_m, AI) and the board. Owns `turn`,

---
 rtl/turn_sched_m_pkg.sv | 45 ++++
 rtl/turn_sched_m_submit_edge.sv | 32 +++
 rtl/turn_sched_m.sv | 179 +++++++++++++++++
 tb/tb_turn_sched_m.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_sched_m_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turn_sched_m_pkg
// Description : Shared types and encodings for the game turn sequencer:
//               bus field types, mover identities, FSM state encoding and
//               winner codes.
// Revision    : 1.0 - initial release
// ============================================================================
package turn_sched_m_pkg;

    // Single-bit shared-bus field and board cell index.
    typedef logic       flag_t;
    typedef logic [3:0] index_t;

    // Mover identities; also the mark written to the board.
    localparam flag_t TURN_PLAYER = 1'b0;
    localparam flag_t TURN_AI     = 1'b1;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_MOVE = 3'd1,
        ST_CHECK     = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_EVAL      = 3'd4,
        ST_OVER      = 3'd5,
        ST_CLEAR     = 3'd6
    } state_t;

    // Game result codes.
    localparam logic [1:0] WINNER_NONE   = 2'b00;
    localparam logic [1:0] WINNER_PLAYER = 2'b01;
    localparam logic [1:0] WINNER_AI     = 2'b10;
    localparam logic [1:0] WINNER_DRAW   = 2'b11;

    // Highest valid board cell.
    localparam index_t c_last_cell = 4'd8;

    // Winner code naming a given mover.
    function automatic logic [1:0] winner_of(input flag_t mover);
        return (mover == TURN_AI) ? WINNER_AI : WINNER_PLAYER;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turn_sched_m_submit_edge.sv
`default_nettype none
// ============================================================================
// Module      : submit_edge_m
// Description : Registers the shared submit strobe and produces a registered
//               one-cycle rising-edge event. A level held high for many
//               cycles yields a single event.
// Revision    : 1.0 - initial release
// ============================================================================
module submit_edge_m
    import turn_sched_m_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  flag_t submit,
    output logic  submit_edge
);

    logic r_submit_q;

    // Sample the bus strobe and flag the first cycle it is seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_submit_q  <= 1'b0;
            submit_edge <= 1'b0;
        end else begin
            r_submit_q  <= submit;
            submit_edge <= submit & ~r_submit_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/turn_sched_m.sv
`default_nettype none
// ============================================================================
// Module      : turn_sched_m
// Description : Game sequencer between the player and AI movers and the
//               board. Owns the bus turn, validates each submitted move,
//               issues one board write, evaluates win/draw, then passes the
//               turn, ends the game, or clears the board on request.
//               Optional macro TURN_TIMEOUT_EN enables an idle-move forfeit.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_sched_m
    import turn_sched_m_pkg::*;
#(
    parameter flag_t       FIRST_MOVER = TURN_PLAYER,
    parameter int unsigned MAX_TURNS   = 9,
    parameter int unsigned TIMEOUT_CYC = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  index_t      update_loc,
    input  flag_t       submit,
    input  flag_t       reset,
    input  logic [8:0]  cell_busy,
    input  flag_t       win,
    output flag_t       turn,
    output logic        wr_en,
    output index_t      wr_loc,
    output flag_t       wr_mark,
    output logic        clear,
    output logic        illegal,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  turn_count
);

    state_t      r_state;
    index_t      r_loc_s;
    flag_t       r_reset_s;
    index_t      r_loc;
    logic        w_event;
    logic [15:0] w_busy_ext;
    logic        w_bad_loc;
    logic        w_timeout;

    submit_edge_m u_submit_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .submit      (submit),
        .submit_edge (w_event)
    );

    // Capture the bus fields alongside the submit register so they line up
    // with the registered edge event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loc_s   <= '0;
            r_reset_s <= 1'b0;
        end else begin
            r_loc_s   <= update_loc;
            r_reset_s <= reset;
        end
    end

    // Zero-extended occupancy so out-of-range locations index safely.
    assign w_busy_ext = {7'd0, cell_busy};
    assign w_bad_loc  = (r_loc > c_last_cell) || w_busy_ext[r_loc];

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned c_to_w = $clog2(TIMEOUT_CYC + 1);
    logic [c_to_w-1:0] r_to_cnt;

    // Count idle cycles in WAIT_MOVE; restart on every entry, saturate at limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_WAIT_MOVE) begin
            r_to_cnt <= '0;
        end else if (32'(r_to_cnt) != TIMEOUT_CYC) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (32'(r_to_cnt) + 32'd1 >= TIMEOUT_CYC);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYC;
    assign w_timeout        = 1'b0;
`endif

    // Sequencer FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_loc      <= '0;
            turn       <= FIRST_MOVER;
            wr_en      <= 1'b0;
            wr_loc     <= '0;
            wr_mark    <= 1'b0;
            clear      <= 1'b0;
            illegal    <= 1'b0;
            game_over  <= 1'b0;
            winner     <= WINNER_NONE;
            turn_count <= '0;
        end else begin
            wr_en   <= 1'b0;
            clear   <= 1'b0;
            illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_WAIT_MOVE;
                end
                ST_WAIT_MOVE: begin
                    // A clear request takes priority over the proposed cell.
                    if (w_event) begin
                        if (r_reset_s) begin
                            r_state <= ST_CLEAR;
                        end else begin
                            r_loc   <= r_loc_s;
                            r_state <= ST_CHECK;
                        end
                    end else if (w_timeout) begin
                        game_over <= 1'b1;
                        winner    <= winner_of(~turn);
                        r_state   <= ST_OVER;
                    end
                end
                ST_CHECK: begin
                    if (w_bad_loc) begin
                        illegal <= 1'b1;
                        r_state <= ST_WAIT_MOVE;
                    end else begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    wr_en      <= 1'b1;
                    wr_loc     <= r_loc;
                    wr_mark    <= turn;
                    turn_count <= turn_count + 4'd1;
                    r_state    <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (win) begin
                        game_over <= 1'b1;
                        winner    <= winner_of(turn);
                        r_state   <= ST_OVER;
                    end else if (turn_count == 4'(MAX_TURNS)) begin
                        game_over <= 1'b1;
                        winner    <= WINNER_DRAW;
                        r_state   <= ST_OVER;
                    end else begin
                        turn    <= ~turn;
                        r_state <= ST_WAIT_MOVE;
                    end
                end
                ST_OVER: begin
                    // Only a clear request leaves a finished game.
                    if (w_event && r_reset_s) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    clear      <= 1'b1;
                    turn       <= FIRST_MOVER;
                    turn_count <= '0;
                    winner     <= WINNER_NONE;
                    game_over  <= 1'b0;
                    r_state    <= ST_WAIT_MOVE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_turn_sched_m.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_sched_m
// Description : Scoreboard bench for turn_sched_m. Stimulus pushes expected
//               board-side events; a monitor pops and compares them as the
//               DUT produces write, illegal, clear and game-end outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_sched_m;
    import turn_sched_m_pkg::*;

    localparam int K_WR   = 0;
    localparam int K_ILL  = 1;
    localparam int K_CLR  = 2;
    localparam int K_OVER = 3;

    typedef struct {
        int kind;
        int loc;
        int mark;
        int cnt;
        int wnr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    index_t     update_loc = '0;
    flag_t      submit = 1'b0;
    flag_t      reset = 1'b0;
    flag_t      win = 1'b0;
    logic [8:0] cell_busy;
    flag_t      turn;
    logic       wr_en;
    index_t     wr_loc;
    flag_t      wr_mark;
    logic       clear;
    logic       illegal;
    logic       game_over;
    logic [1:0] winner;
    logic [3:0] turn_count;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic go_q = 1'b0;

    turn_sched_m #(
        .FIRST_MOVER (TURN_PLAYER),
        .MAX_TURNS   (9),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .update_loc (update_loc),
        .submit     (submit),
        .reset      (reset),
        .cell_busy  (cell_busy),
        .win        (win),
        .turn       (turn),
        .wr_en      (wr_en),
        .wr_loc     (wr_loc),
        .wr_mark    (wr_mark),
        .clear      (clear),
        .illegal    (illegal),
        .game_over  (game_over),
        .winner     (winner),
        .turn_count (turn_count)
    );

    always #5 clk = ~clk;

    // Board model: marks written cells, empties on clear or reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cell_busy <= '0;
        else if (clear)                cell_busy <= '0;
        else if (wr_en && wr_loc <= 8) cell_busy[wr_loc] <= 1'b1;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic push(input int kind, input int loc, input int mark,
                        input int cnt, input int wnr);
        exp_t e;
        e.kind = kind; e.loc = loc; e.mark = mark; e.cnt = cnt; e.wnr = wnr;
        sb.push_back(e);
    endtask

    task automatic take(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (sb.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
        end else begin
            e  = sb.pop_front();
            chk("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    // Monitor: every DUT-side event must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (rst_n) begin
            if (wr_en) begin
                take(K_WR, e, ok);
                if (ok) begin
                    chk("wr_loc", int'(wr_loc), e.loc);
                    chk("wr_mark", int'(wr_mark), e.mark);
                    chk("wr_count", int'(turn_count), e.cnt);
                end
            end
            if (illegal) begin
                take(K_ILL, e, ok);
                if (ok) begin
                    chk("ill_turn", int'(turn), e.mark);
                    chk("ill_count", int'(turn_count), e.cnt);
                end
            end
            if (clear) begin
                take(K_CLR, e, ok);
                if (ok) begin
                    chk("clr_turn", int'(turn), e.mark);
                    chk("clr_count", int'(turn_count), e.cnt);
                    chk("clr_winner", int'(winner), e.wnr);
                    chk("clr_game_over", int'(game_over), 0);
                end
            end
            if (game_over && !go_q) begin
                take(K_OVER, e, ok);
                if (ok) begin
                    chk("over_winner", int'(winner), e.wnr);
                    chk("over_count", int'(turn_count), e.cnt);
                end
            end
        end
        go_q = game_over;
    end

    // One bus transaction: raise submit for 'hold' cycles, then let it settle.
    task automatic move(input int loc, input bit rs, input int hold);
        int l;
        l = loc;
        @(negedge clk);
        update_loc = l[3:0];
        reset      = rs;
        submit     = 1'b1;
        repeat (hold) @(negedge clk);
        submit     = 1'b0;
        reset      = 1'b0;
        update_loc = '0;
        repeat (7) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_turn", int'(turn), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_count", int'(turn_count), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_clear", int'(clear), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Player move to cell 2 with latency checks
        push(K_WR, 2, 0, 1, 0);
        @(negedge clk);
        update_loc = 4'd2;
        submit     = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("lat_wr_en_early", int'(wr_en), 0);
        @(posedge clk);
        #1 chk("lat_wr_en", int'(wr_en), 1);
        chk("lat_turn_hold", int'(turn), 0);
        @(posedge clk);
        #1 chk("lat_turn_toggle", int'(turn), 1);
        submit     = 1'b0;
        update_loc = '0;
        repeat (4) @(negedge clk);
        chk("count_after_first", int'(turn_count), 1);

        // AI move to cell 4
        push(K_WR, 4, 1, 2, 0);
        move(4, 1'b0, 1);
        chk("turn_after_ai", int'(turn), 0);

        // Occupied cell, then out-of-range cells
        push(K_ILL, 0, 0, 2, 0);
        move(4, 1'b0, 1);
        push(K_ILL, 0, 0, 2, 0);
        move(9, 1'b0, 1);
        push(K_ILL, 0, 0, 2, 0);
        move(15, 1'b0, 1);
        chk("turn_after_illegal", int'(turn), 0);
        chk("count_after_illegal", int'(turn_count), 2);

        // Player cell 0, AI cell 8 wins
        push(K_WR, 0, 0, 3, 0);
        move(0, 1'b0, 1);
        win = 1'b1;
        push(K_WR, 8, 1, 4, 0);
        push(K_OVER, 0, 1, 4, 2);
        move(8, 1'b0, 1);
        win = 1'b0;
        chk("ai_win_game_over", int'(game_over), 1);
        chk("ai_win_winner", int'(winner), 2);

        // Move event ignored after game end
        move(5, 1'b0, 1);
        chk("over_hold_game_over", int'(game_over), 1);
        chk("over_hold_count", int'(turn_count), 4);

        // Clear request
        push(K_CLR, 0, 0, 0, 0);
        move(5, 1'b1, 1);
        chk("clear_turn", int'(turn), 0);
        chk("clear_board", int'(cell_busy), 0);

        // Nine legal moves, no win: draw; first submit held 20 cycles
        for (int i = 0; i < 9; i++) begin
            push(K_WR, i, i % 2, i + 1, 0);
            if (i == 8) push(K_OVER, 0, 0, 9, 3);
            move(i, 1'b0, (i == 0) ? 20 : 1);
        end
        chk("draw_winner", int'(winner), 3);
        chk("draw_count", int'(turn_count), 9);

        // Clear wins over a simultaneous move location
        push(K_CLR, 0, 0, 0, 0);
        move(3, 1'b1, 1);
        chk("clear2_count", int'(turn_count), 0);

        // Long idle period in WAIT_MOVE
`ifdef TURN_TIMEOUT_EN
        push(K_OVER, 0, 0, 0, 2);
        repeat (1000) @(negedge clk);
        chk("timeout_winner", int'(winner), 2);
        push(K_CLR, 0, 0, 0, 0);
        move(0, 1'b1, 1);
`else
        repeat (1000) @(negedge clk);
        chk("idle_game_over", int'(game_over), 0);
        push(K_WR, 3, 0, 1, 0);
        move(3, 1'b0, 1);
        chk("idle_then_turn", int'(turn), 1);
`endif

        // Reset asserted while a move is in flight
        @(negedge clk);
        update_loc = 4'd6;
        submit     = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midrst_turn", int'(turn), 0);
        chk("midrst_count", int'(turn_count), 0);
        chk("midrst_wr_en", int'(wr_en), 0);
        submit     = 1'b0;
        update_loc = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_board", int'(cell_busy), 0);

        chk("sb_leftover", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
